encoder_fsm: RTL and testbench
==============================

ENCODER_FSM -- requirements
Module: encoder_fsm

Interface
REQ-001 Parameter LEN_TX_TYPE, default 4: width of the block-type code.
REQ-002 Parameter LEN_CODED_BLOCK, default 66: width of the coded block (sync header in bits [65:64]).
REQ-003 i_clock  input  1  clock for all sequential logic.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_enable  input  1  block strobe; state and outputs advance only when high.
REQ-006 i_tx_type  input  LEN_TX_TYPE  type of the current block from the encoder classifier.
REQ-007 i_tx_coded  input  LEN_CODED_BLOCK  encoded block matching i_tx_type.
REQ-008 o_tx_coded  output  LEN_CODED_BLOCK  block to scrambler: pass-through, EBLOCK_T or LBLOCK_T.
REQ-009 o_tx_state  output  3  current FSM state code.
REQ-010 o_err_count  output  16  count of blocks replaced by EBLOCK_T (see Configuration).

Function
REQ-011 The block SHALL implement the transmit 64b/66b control FSM with states TX_INIT=0, TX_C=1, TX_D=2, TX_T=3, TX_E=4.
REQ-012 Type codes SHALL be TYPE_C=1, TYPE_S=2, TYPE_D=3, TYPE_T=4, TYPE_E=5; any other value, including 0, SHALL be treated as TYPE_E.
REQ-013 From TX_INIT, TX_C and TX_T: C->TX_C, S->TX_D, else->TX_E.
REQ-014 From TX_D: D->TX_D, T->TX_T, else->TX_E.
REQ-015 From TX_E: C->TX_C, D->TX_D, T->TX_T, else->TX_E (S from TX_E->TX_E).
REQ-016 Next state SHALL be computed combinationally from the current state and i_tx_type, then registered on the i_enable cycle.
REQ-017 o_tx_coded SHALL be registered with 1 enabled-cycle latency: EBLOCK_T if the next state is TX_E, else i_tx_coded.
REQ-018 o_tx_state SHALL equal the registered state, so it aligns with the o_tx_coded it produced.
REQ-019 With i_enable low, state, o_tx_coded and o_err_count SHALL hold; i_tx_type and i_tx_coded are ignored.
REQ-020 EBLOCK_T SHALL be 66'h2_1E3C78F1E3C78F1E (sync 10, type 0x1E, eight /E/ codes 0x1E).
REQ-021 LBLOCK_T SHALL be 66'h2_4B00000100000000 (sync 10, type 0x4B, local-fault ordered set).

Reset
REQ-022 On i_reset assertion, state SHALL go to TX_INIT, o_tx_coded to LBLOCK_T and o_err_count to 0, immediately and asynchronously.
REQ-023 After reset release, o_tx_coded SHALL remain LBLOCK_T until the first enabled cycle.
REQ-024 Reset asserted mid-packet (TX_D) SHALL abort with no EBLOCK_T emitted; the first enabled block after release is evaluated from TX_INIT.

Configuration
REQ-025 Macro ENCODER_FSM_ERR_CNT_EN defined: o_err_count SHALL increment by 1 on every enabled cycle whose output is EBLOCK_T, saturating at 16'hFFFF.
REQ-026 Macro ENCODER_FSM_ERR_CNT_EN undefined: counter logic SHALL be omitted and o_err_count tied to 0; port list unchanged.

Structure
REQ-027 A shared package SHALL hold the state codes, type codes, LEN_TX_TYPE, LEN_CODED_BLOCK, EBLOCK_T and LBLOCK_T; the receive-side decoder FSM SHALL use the same type codes.
REQ-028 The saturating counter SHALL be the sub-module encoder_err_counter, instantiated only under ENCODER_FSM_ERR_CNT_EN.

Verification
REQ-029 Reset, then types C,S,D,D,T,C each with i_enable=1 -> states 1,2,2,2,3,1; o_tx_coded equals the input blocks one cycle later; o_err_count=0.
REQ-030 Types S,D,C (C inside packet) -> states 2,2,4; third output EBLOCK_T; o_err_count=1.
REQ-031 From TX_E: S -> stays TX_E with EBLOCK_T; then D -> TX_D with the input block passed through.
REQ-032 Type 0 and type 4'hF from TX_C -> TX_E and EBLOCK_T each cycle; o_err_count increments by 2.
REQ-033 i_enable toggled 1,0,0,1 with changing inputs -> outputs and state change only on the two enabled cycles.
REQ-034 i_reset pulsed while in TX_D between clock edges -> o_tx_coded=LBLOCK_T and o_tx_state=0 before the next edge; counter preloaded to 16'hFFFE then three TYPE_E -> saturates at 16'hFFFF (macro defined) or stays 0 (undefined).

Source files
------------

// File: rtl/encoder_fsm_pkg.sv
// Shared 64b/66b control constants: state codes, block-type codes and
// the fixed error / local-fault blocks used by encoder and decoder FSMs.
package encoder_fsm_pkg;

   localparam int LEN_TX_TYPE     = 4;
   localparam int LEN_CODED_BLOCK = 66;

   typedef enum logic [2:0] {
      TX_INIT = 3'd0,
      TX_C    = 3'd1,
      TX_D    = 3'd2,
      TX_T    = 3'd3,
      TX_E    = 3'd4
   } tx_state_e;

   // Receive side decodes with these same codes; anything else is TYPE_E.
   localparam logic [3:0] TYPE_C = 4'd1;
   localparam logic [3:0] TYPE_S = 4'd2;
   localparam logic [3:0] TYPE_D = 4'd3;
   localparam logic [3:0] TYPE_T = 4'd4;
   localparam logic [3:0] TYPE_E = 4'd5;

   localparam logic [65:0] EBLOCK_T = 66'h2_1E3C78F1E3C78F1E;
   localparam logic [65:0] LBLOCK_T = 66'h2_4B00000100000000;

endpackage

// File: rtl/encoder_fsm_err_counter.sv
// Saturating 16-bit count of blocks replaced by EBLOCK_T.
import encoder_fsm_pkg::*;

module encoder_err_counter (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_inc,
   output logic [15:0] o_count
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_inc && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign o_count = cnt_q;

endmodule

// File: rtl/encoder_fsm.sv
// Transmit 64b/66b control FSM; replaces illegal sequences with EBLOCK_T.
// Define ENCODER_FSM_ERR_CNT_EN to build the saturating error counter.
import encoder_fsm_pkg::*;

module encoder_fsm #(
   parameter int LEN_TX_TYPE     = 4,
   parameter int LEN_CODED_BLOCK = 66
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_enable,
   input  logic [LEN_TX_TYPE-1:0]     i_tx_type,
   input  logic [LEN_CODED_BLOCK-1:0] i_tx_coded,
   output logic [LEN_CODED_BLOCK-1:0] o_tx_coded,
   output logic [2:0]                 o_tx_state,
   output logic [15:0]                o_err_count
);

   tx_state_e                  state_q;
   tx_state_e                  state_d;
   logic [LEN_CODED_BLOCK-1:0] coded_q;
   logic [LEN_CODED_BLOCK-1:0] coded_d;
   logic                       is_c;
   logic                       is_s;
   logic                       is_d;
   logic                       is_t;

   assign is_c = (i_tx_type == LEN_TX_TYPE'(TYPE_C));
   assign is_s = (i_tx_type == LEN_TX_TYPE'(TYPE_S));
   assign is_d = (i_tx_type == LEN_TX_TYPE'(TYPE_D));
   assign is_t = (i_tx_type == LEN_TX_TYPE'(TYPE_T));

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= TX_INIT;
         coded_q <= LEN_CODED_BLOCK'(LBLOCK_T);
      end else if (i_enable) begin
         state_q <= state_d;
         coded_q <= coded_d;
      end
   end

   // Every unlisted type/state pair falls through to TX_E.
   always_comb begin
      state_d = TX_E;
      unique case (state_q)
         TX_INIT, TX_C, TX_T: begin
            if (is_c)      state_d = TX_C;
            else if (is_s) state_d = TX_D;
         end
         TX_D: begin
            if (is_d)      state_d = TX_D;
            else if (is_t) state_d = TX_T;
         end
         TX_E: begin
            if (is_c)      state_d = TX_C;
            else if (is_d) state_d = TX_D;
            else if (is_t) state_d = TX_T;
         end
         default: state_d = TX_E;
      endcase
   end

   always_comb begin
      coded_d = i_tx_coded;
      if (state_d == TX_E) coded_d = LEN_CODED_BLOCK'(EBLOCK_T);
   end

   assign o_tx_coded = coded_q;
   assign o_tx_state = state_q;

`ifdef ENCODER_FSM_ERR_CNT_EN
   logic err_inc;

   assign err_inc = i_enable && (state_d == TX_E);

   encoder_err_counter u_err_cnt (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_inc   (err_inc),
      .o_count (o_err_count)
   );
`else
   assign o_err_count = '0;
`endif

endmodule

// File: tb/tb_encoder_fsm.sv
// Self-checking bench for encoder_fsm against a table-driven reference.
module tb_encoder_fsm;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  ty;
   logic [65:0] cin;
   logic [65:0] cout;
   logic [2:0]  st;
   logic [15:0] errc;

   int checks;
   int errors;

   localparam logic [65:0] EBLK = 66'h2_1E3C78F1E3C78F1E;
   localparam logic [65:0] LBLK = 66'h2_4B00000100000000;

   // nxt[state][type-1], type columns C,S,D,T,E
   int          nxt [5][5];
   int          m_state;
   logic [65:0] m_coded;
   int          m_err;

   encoder_fsm dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_enable    (en),
      .i_tx_type   (ty),
      .i_tx_coded  (cin),
      .o_tx_coded  (cout),
      .o_tx_state  (st),
      .o_err_count (errc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [65:0] got,
                        input logic [65:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_state = 0;
      m_coded = LBLK;
      m_err   = 0;
   endtask

   task automatic m_step(input logic e, input logic [3:0] t,
                         input logic [65:0] c);
      int col;
      if (!e) return;
      col = (t >= 4'd1 && t <= 4'd5) ? int'(t) - 1 : 4;
      m_state = nxt[m_state][col];
      m_coded = (m_state == 4) ? EBLK : c;
`ifdef ENCODER_FSM_ERR_CNT_EN
      if (m_state == 4 && m_err < 65535) m_err++;
`endif
   endtask

   task automatic cmp(input string tag);
      check({tag, ".state"}, 66'(st), 66'(m_state));
      check({tag, ".coded"}, cout, m_coded);
      check({tag, ".err"}, 66'(errc), 66'(m_err));
   endtask

   task automatic blk(input string tag, input logic e, input logic [3:0] t,
                      input logic [65:0] c, input bit do_chk);
      @(negedge clk);
      en  = e;
      ty  = t;
      cin = c;
      m_step(e, t, c);
      @(posedge clk);
      #1;
      if (do_chk) cmp(tag);
   endtask

   function automatic logic [65:0] rblk();
      return {2'($urandom), $urandom, $urandom};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      en  = 1'b0;
      rst = 1'b1;
      m_reset();
      #1;
      cmp("rst");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] seq [6];
      logic [3:0] tt;
      checks = 0;
      errors = 0;
      nxt[0] = '{1, 2, 4, 4, 4};
      nxt[1] = '{1, 2, 4, 4, 4};
      nxt[3] = '{1, 2, 4, 4, 4};
      nxt[2] = '{4, 4, 2, 3, 4};
      nxt[4] = '{1, 4, 2, 3, 4};
      rst = 1'b1;
      en  = 1'b0;
      ty  = 4'd0;
      cin = '0;
      m_reset();
      #2;
      cmp("por");
      do_reset();

      blk("hold_lblk", 1'b0, 4'd3, rblk(), 1'b1);

      seq = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd1};
      foreach (seq[i]) blk("pkt", 1'b1, seq[i], rblk(), 1'b1);

      blk("bad_s", 1'b1, 4'd2, rblk(), 1'b1);
      blk("bad_d", 1'b1, 4'd3, rblk(), 1'b1);
      blk("bad_c", 1'b1, 4'd1, rblk(), 1'b1);

      blk("e_s", 1'b1, 4'd2, rblk(), 1'b1);
      blk("e_d", 1'b1, 4'd3, rblk(), 1'b1);

      blk("to_c", 1'b1, 4'd1, rblk(), 1'b1);
      blk("ty0", 1'b1, 4'd0, rblk(), 1'b1);
      blk("to_c2", 1'b1, 4'd1, rblk(), 1'b1);
      blk("tyF", 1'b1, 4'hF, rblk(), 1'b1);

      blk("en1", 1'b1, 4'd1, rblk(), 1'b1);
      blk("en0a", 1'b0, 4'd2, rblk(), 1'b1);
      blk("en0b", 1'b0, 4'd7, rblk(), 1'b1);
      blk("en1b", 1'b1, 4'd2, rblk(), 1'b1);

      for (int i = 0; i < 300; i++) begin
         tt = ($urandom_range(0, 7) == 0) ? 4'($urandom)
                                          : 4'($urandom_range(1, 5));
         blk("rnd", ($urandom_range(0, 3) != 0), tt, rblk(), 1'b1);
      end

      blk("mid_c", 1'b1, 4'd1, rblk(), 1'b1);
      blk("mid_s", 1'b1, 4'd2, rblk(), 1'b1);
      blk("mid_d", 1'b1, 4'd3, rblk(), 1'b1);
      #2;
      rst = 1'b1;
      m_reset();
      #1;
      cmp("abort");
      en  = 1'b0;
      #1;
      rst = 1'b0;
      blk("post_hold", 1'b0, 4'd3, rblk(), 1'b1);
      blk("post_d", 1'b1, 4'd3, rblk(), 1'b1);

      do_reset();
`ifdef ENCODER_FSM_ERR_CNT_EN
      for (int i = 0; i < 65534; i++) blk("fill", 1'b1, 4'd5, '0, 1'b0);
      cmp("preload");
`endif
      for (int i = 0; i < 3; i++) blk("sat", 1'b1, 4'd5, rblk(), 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got 1 exp 0");
      $fatal(1);
   end

endmodule
